// File: rtl/video_pattern_source.sv
// AXI4-Stream video master: synthesizes solid/bars/gradient/checker frames.
// Ports: m_axis_vid_* stream (tdata {8'h00,B,G,R}, tuser=SOF, tlast=EOL),
// control_op/control_data config bus, frame_count, busy.
// Optional VSRC_FRAME_STAMP_EN: SOF beat carries {16'hA55A, frame_count}.
module video_pattern_source #(
    parameter int MAXWIDTH  = 1280,
    parameter int FRAME_GAP = 16
) (
    input  logic        m_axis_vid_aclk,
    input  logic        areset,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tlast,
    output logic        m_axis_vid_tuser,
    input  logic [31:0] control_data,
    input  logic [7:0]  control_op,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam logic [7:0] OP_DIMENSIONS = 8'd2;
    localparam logic [7:0] OP_RESET      = 8'd11;
    localparam logic [7:0] OP_PATTERN    = 8'd13;
    localparam logic [7:0] OP_ENABLE     = 8'd14;
    localparam logic [7:0] OP_SOLID      = 8'd15;

    localparam logic [11:0] MAXW = 12'(MAXWIDTH);
    localparam int GW = (FRAME_GAP > 2) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE,
        ST_GAP
    } state_t;

    function automatic logic [23:0] pattern_px(
        input logic [1:0]  pat,
        input logic [11:0] px,
        input logic [11:0] py,
        input logic [23:0] solid
    );
        logic [11:0] s;
        logic [23:0] r;
        s = px + py;
        r = 24'h0;
        case (pat)
            2'd0: r = solid;
            2'd1: begin
                case (px[9:7])
                    3'd0:    r = 24'hFFFFFF;
                    3'd1:    r = 24'h00FFFF;
                    3'd2:    r = 24'hFFFF00;
                    3'd3:    r = 24'h00FF00;
                    3'd4:    r = 24'hFF00FF;
                    3'd5:    r = 24'h0000FF;
                    3'd6:    r = 24'hFF0000;
                    default: r = 24'h000000;
                endcase
            end
            2'd2:    r = {s[7:0], py[7:0], px[7:0]};
            default: r = (px[4] ^ py[4]) ? 24'hFFFFFF : 24'h000000;
        endcase
        return r;
    endfunction

    // Control bus is registered once before decode.
    logic [7:0]  op_q;
    logic [31:0] data_q;
    logic [11:0] cfg_width;
    logic [11:0] cfg_height;
    logic [1:0]  cfg_pattern;
    logic [23:0] cfg_solid;
    logic        cfg_enable;

    logic unused_data;
    assign unused_data = ^data_q[31:28];

    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            op_q        <= 8'd0;
            data_q      <= 32'd0;
            cfg_width   <= 12'd720;
            cfg_height  <= 12'd576;
            cfg_pattern <= 2'd1;
            cfg_solid   <= 24'd0;
            cfg_enable  <= 1'b0;
        end else begin
            op_q   <= control_op;
            data_q <= control_data;
            case (op_q)
                OP_DIMENSIONS: begin
                    cfg_height <= data_q[27:16];
                    cfg_width  <= data_q[11:0];
                end
                OP_RESET: begin
                    cfg_width   <= 12'd720;
                    cfg_height  <= 12'd576;
                    cfg_pattern <= 2'd1;
                    cfg_solid   <= 24'd0;
                    cfg_enable  <= 1'b0;
                end
                OP_PATTERN: cfg_pattern <= data_q[1:0];
                OP_SOLID:   cfg_solid   <= data_q[23:0];
                OP_ENABLE:  cfg_enable  <= data_q[0];
                default: ;
            endcase
        end
    end

    logic [11:0] wclamp;
    logic        dims_ok;
    logic        cfg_ok;
    assign wclamp  = (cfg_width > MAXW) ? MAXW : cfg_width;
    assign dims_ok = (cfg_width != 12'd0) && (cfg_height != 12'd0);
    assign cfg_ok  = cfg_enable && dims_ok;

    state_t        state;
    logic [11:0]   x;
    logic [11:0]   y;
    logic [11:0]   wid;
    logic [11:0]   hgt;
    logic [1:0]    pat_s;
    logic [GW-1:0] gap_cnt;
    logic          last_x;
    logic          last_y;

    assign last_x = (x == wid - 12'd1);
    assign last_y = (y == hgt - 12'd1);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            state             <= ST_IDLE;
            x                 <= 12'd0;
            y                 <= 12'd0;
            wid               <= 12'd0;
            hgt               <= 12'd0;
            pat_s             <= 2'd0;
            gap_cnt           <= '0;
            m_axis_vid_tdata  <= 32'd0;
            m_axis_vid_tvalid <= 1'b0;
            m_axis_vid_tlast  <= 1'b0;
            m_axis_vid_tuser  <= 1'b0;
            frame_count       <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    m_axis_vid_tdata  <= 32'd0;
                    m_axis_vid_tvalid <= 1'b0;
                    m_axis_vid_tlast  <= 1'b0;
                    m_axis_vid_tuser  <= 1'b0;
                    if (cfg_ok)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    // Dimensions may have been zeroed since leaving IDLE.
                    if (!dims_ok) begin
                        state <= ST_IDLE;
                    end else begin
                        wid   <= wclamp;
                        hgt   <= cfg_height;
                        pat_s <= cfg_pattern;
                        x     <= 12'd0;
                        y     <= 12'd0;
`ifdef VSRC_FRAME_STAMP_EN
                        m_axis_vid_tdata <= {16'hA55A, frame_count};
`else
                        m_axis_vid_tdata <= {8'h00,
                            pattern_px(cfg_pattern, 12'd0, 12'd0, cfg_solid)};
`endif
                        m_axis_vid_tvalid <= 1'b1;
                        m_axis_vid_tuser  <= 1'b1;
                        m_axis_vid_tlast  <= (wclamp == 12'd1);
                        state             <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (m_axis_vid_tready) begin
                        m_axis_vid_tuser <= 1'b0;
                        if (last_x && last_y) begin
                            frame_count       <= frame_count + 16'd1;
                            m_axis_vid_tdata  <= 32'd0;
                            m_axis_vid_tvalid <= 1'b0;
                            m_axis_vid_tlast  <= 1'b0;
                            gap_cnt           <= '0;
                            if (FRAME_GAP == 0)
                                state <= cfg_ok ? ST_LOAD : ST_IDLE;
                            else
                                state <= ST_GAP;
                        end else if (last_x) begin
                            x                <= 12'd0;
                            y                <= y + 12'd1;
                            m_axis_vid_tdata <= {8'h00,
                                pattern_px(pat_s, 12'd0, y + 12'd1, cfg_solid)};
                            m_axis_vid_tlast <= (wid == 12'd1);
                        end else begin
                            x                <= x + 12'd1;
                            m_axis_vid_tdata <= {8'h00,
                                pattern_px(pat_s, x + 12'd1, y, cfg_solid)};
                            m_axis_vid_tlast <= (x + 12'd1 == wid - 12'd1);
                        end
                    end
                end
                default: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST)
                        state <= cfg_ok ? ST_LOAD : ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_pattern_source.sv
// Bench for video_pattern_source: random backpressure against a
// coordinate-based pixel model.
module tb_video_pattern_source;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic [31:0] control_data;
    logic [7:0]  control_op;
    logic [15:0] frame_count;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_sof = 0;
    int first_n = 0;
    logic [31:0] beats[$];
    logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

    video_pattern_source #(.MAXWIDTH(1280), .FRAME_GAP(GAP)) dut (
        .m_axis_vid_aclk  (clk),
        .areset           (areset),
        .m_axis_vid_tdata (tdata),
        .m_axis_vid_tvalid(tvalid),
        .m_axis_vid_tready(tready),
        .m_axis_vid_tlast (tlast),
        .m_axis_vid_tuser (tuser),
        .control_data     (control_data),
        .control_op       (control_op),
        .frame_count      (frame_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_px(input int pat, input int px,
                                           input int py, input logic [23:0] solid);
        int r, g, b;
        case (pat)
            0: return {8'h00, solid};
            1: return {8'h00, bars[(px / 128) % 8]};
            2: begin
                r = px % 256;
                g = py % 256;
                b = (px + py) % 256;
                return 32'((b << 16) | (g << 8) | r);
            end
            default:
                return (((px / 16) + (py / 16)) % 2 == 1) ? 32'h00FFFFFF : 32'h0;
        endcase
    endfunction

    task automatic send_op(input logic [7:0] op, input logic [31:0] d);
        @(negedge clk);
        control_op   = op;
        control_data = d;
        @(negedge clk);
        control_op = 8'd0;
    endtask

    // Streams one frame, checking every accepted beat; optionally issues
    // one control op right after beat op_at is accepted.
    task automatic run_frame(input int w, input int h, input int pat,
                             input logic [23:0] solid, input int fc0,
                             input int pct, input int op_at,
                             input logic [7:0] op, input logic [31:0] opd);
        int k = 0;
        int n = 0;
        int lim;
        int px, py;
        bit stalled = 0;
        logic [31:0] pd = '0;
        logic pl = 0, pu = 0;
        logic [31:0] exp;
        lim = w * h * 6 + 200;
        beats.delete();
        while (k < w * h && n < lim) begin
            @(negedge clk);
            n++;
            control_op = 8'd0;
            if (stalled) begin
                check("hold_valid", 32'(tvalid), 32'd1);
                check("hold_beat", {tdata[29:0], tlast, tuser},
                      {pd[29:0], pl, pu});
            end
            tready = ($urandom_range(99) < pct);
            if (tvalid && tready) begin
                px = k % w;
                py = k / w;
                exp = ref_px(pat, px, py, solid);
`ifdef VSRC_FRAME_STAMP_EN
                if (k == 0) exp = {16'hA55A, 16'(fc0)};
`endif
                check("pixel", tdata, exp);
                check("tlast", 32'(tlast), 32'(px == w - 1));
                check("tuser", 32'(tuser), 32'(k == 0));
                if (k == 0) begin
                    check("fc_at_sof", 32'(frame_count), 32'(16'(fc0)));
                    last_sof = cyc;
                    first_n  = n;
                end
                beats.push_back(tdata);
                if (k == op_at) begin
                    control_op   = op;
                    control_data = opd;
                end
                k++;
            end
            stalled = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            pu = tuser;
        end
        check("frame_beats", 32'(k), 32'(w * h));
        @(negedge clk);
        control_op = 8'd0;
        check("valid_after_frame", 32'(tvalid), 32'd0);
        check("fc_after_frame", 32'(frame_count), 32'(16'(fc0 + 1)));
        tready = 1'b1;
    endtask

    initial begin
        int sof_a;
        int n;
        bit seen;
        logic [23:0] solid;

        areset       = 1'b1;
        tready       = 1'b1;
        control_op   = 8'd0;
        control_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tlast_tuser", {30'd0, tlast, tuser}, 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        areset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_default", 32'(busy), 32'd0);

        // Gradient frame 4x2 with start-up latency.
        send_op(8'd2, 32'h0002_0004);
        send_op(8'd13, 32'd2);
        @(negedge clk);
        control_op   = 8'd14;
        control_data = 32'd1;
        @(negedge clk);
        control_op = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check("lat_n3_valid", 32'(tvalid), 32'd0);
        check("lat_n3_busy", 32'(busy), 32'd1);
        run_frame(4, 2, 2, 24'h0, 0, 100, -1, 8'd0, 32'd0);
        check("lat_first", 32'(first_n), 32'd1);
        check("grad_beat5", beats[5], 32'h0002_0101);
        sof_a = last_sof;

        // Second frame; dimension change mid-frame applies next frame.
        run_frame(4, 2, 2, 24'h0, 1, 100, 2, 8'd2, 32'h0003_0005);
        check("period", 32'(last_sof - sof_a), 32'(4 * 2 + GAP + 1));

        // Backpressure, pattern change mid-frame.
        run_frame(5, 3, 2, 24'h0, 2, 50, 3, 8'd13, 32'd3);
        // Disable mid-frame: frame completes, then idle.
        run_frame(5, 3, 3, 24'h0, 3, 50, 4, 8'd14, 32'd0);
        repeat (GAP - 1) @(negedge clk);
        check("gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("post_gap_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tvalid) seen = 1;
        end
        check("disabled_quiet", 32'(seen), 32'd0);
        check("disabled_fc", 32'(frame_count), 32'd4);

        // W=1 solid frame.
        solid = 24'($urandom);
        send_op(8'd15, {8'h00, solid});
        send_op(8'd13, 32'd0);
        send_op(8'd2, 32'h0003_0001);
        send_op(8'd14, 32'd1);
        run_frame(1, 3, 0, solid, 4, 100, -1, 8'd0, 32'd0);

        // Reset mid-frame.
        n = 0;
        while (!tvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", 32'(tvalid), 32'd1);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        check("mid_rst_valid", 32'(tvalid), 32'd0);
        check("mid_rst_fc", 32'(frame_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("rst_enable_off", 32'(busy), 32'd0);

        // Colour bars from default pattern, W=256; then stamp frame.
        send_op(8'd2, 32'h0002_0100);
        send_op(8'd14, 32'd1);
        run_frame(256, 2, 1, 24'h0, 0, 75, -1, 8'd0, 32'd0);
        check("bars_x130", beats[130], 32'h0000_FFFF);
        run_frame(256, 2, 1, 24'h0, 1, 100, 0, 8'd2, 32'h0001_0FA0);
`ifdef VSRC_FRAME_STAMP_EN
        check("stamp_sof", beats[0], 32'hA55A_0001);
`else
        check("sof_pixel", beats[0], 32'h00FF_FFFF);
`endif
        // Width 4000 clamps to 1280.
        run_frame(1280, 1, 1, 24'h0, 2, 100, 10, 8'd14, 32'd0);
        check("clamp_last", beats[1279], 32'h0000_FFFF);
        repeat (GAP + 4) @(negedge clk);
        check("clamp_idle", 32'(busy), 32'd0);

        // Zero width with enable: stays idle.
        send_op(8'd2, 32'h0005_0000);
        send_op(8'd14, 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (tvalid || busy) seen = 1;
        end
        check("zero_w_idle", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
